// File: rtl/snn_pkg.sv
// Shared types for the spike packing path: default spike vector width, vector type,
// the packed-word record carried by the output FIFO, and a popcount helper.
package snn_pkg;

  localparam int unsigned SNN_T     = 16;
  localparam int unsigned SNN_NPACK = 4;
  localparam int unsigned SNN_W     = SNN_T * SNN_NPACK;
  localparam int unsigned SNN_CNT_W = $clog2(SNN_NPACK + 1);
  localparam int unsigned SNN_PC_W  = $clog2(SNN_T + 1);

  typedef logic [SNN_T-1:0] spike_vec_t;

  typedef struct packed {
    logic [SNN_W-1:0]     data;
    logic [SNN_CNT_W-1:0] count;
    logic                 last;
  } pack_word_t;

  function automatic logic [SNN_PC_W-1:0] popcount(input spike_vec_t v);
    logic [SNN_PC_W-1:0] pc;
    pc = '0;
    for (int i = 0; i < int'(SNN_T); i++) begin
      pc = pc + SNN_PC_W'(v[i]);
    end
    return pc;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on rd_data whenever !empty.
// A push is refused while full, even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/spike_pack_buffer.sv
// Packs NPACK LIF spike vectors into one word and streams words out through a FIFO.
// Define SPIKE_PACK_STATS_EN to build the saturating accepted-spike counter on spike_total.
module spike_pack_buffer
  import snn_pkg::*;
#(
  parameter int unsigned T     = SNN_T,
  parameter int unsigned NPACK = SNN_NPACK,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [T-1:0]               spike_in,
  input  logic                       spike_valid,
  input  logic                       spike_last,
  input  logic                       flush,
  output logic                       in_ready,
  output logic [T*NPACK-1:0]         out_data,
  output logic [$clog2(NPACK+1)-1:0] out_count,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow,
  input  logic                       clr,
  output logic [31:0]                spike_total
);

  localparam int unsigned W      = T * NPACK;
  localparam int unsigned CNT_W  = $clog2(NPACK + 1);
  localparam int unsigned SLOT_W = (NPACK > 1) ? $clog2(NPACK) : 1;
  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [W-1:0]      pack_q, pack_d;
  logic              pend_q, pend_d;
  logic              overflow_q, overflow_d;
  logic [W-1:0]      merged;
  logic              accept, drop, close, push;
  logic              fifo_full, fifo_empty;
  logic [FCNT_W-1:0] fifo_cnt;
  pack_word_t        push_word, head_word;

  assign in_ready  = !fifo_full && !pend_q;
  assign accept    = spike_valid && in_ready;
  assign drop      = spike_valid && !in_ready;
  assign close     = spike_last || flush;
  assign out_valid = !fifo_empty;
  assign out_data  = head_word.data;
  assign out_count = head_word.count;
  assign out_last  = head_word.last;
  assign overflow  = overflow_q;

  // Slot fill, word close on full/last/flush, and deferred flush while the FIFO is full
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    pack_d     = pack_q;
    pend_d     = pend_q;
    push       = 1'b0;
    push_word  = '0;
    merged     = pack_q;
    for (int k = 0; k < int'(NPACK); k++) begin
      if (SLOT_W'(k) == slot_cnt_q) begin
        merged[k*T +: T] = spike_in;
      end
    end
    if (accept) begin
      if ((slot_cnt_q == SLOT_W'(NPACK - 1)) || close) begin
        push            = 1'b1;
        push_word.data  = merged;
        push_word.count = CNT_W'(slot_cnt_q) + CNT_W'(1);
        push_word.last  = close;
        slot_cnt_d      = '0;
        pack_d          = '0;
      end else begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        pack_d     = merged;
      end
    end else if (pend_q || (flush && (slot_cnt_q != '0))) begin
      if (fifo_cnt != FCNT_W'(DEPTH)) begin
        push            = 1'b1;
        push_word.data  = pack_q;
        push_word.count = CNT_W'(slot_cnt_q);
        push_word.last  = 1'b1;
        slot_cnt_d      = '0;
        pack_d          = '0;
        pend_d          = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q <= '0;
      pack_q     <= '0;
      pend_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      pack_q     <= pack_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH($bits(pack_word_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (push_word),
    .pop     (out_ready),
    .rd_data (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

`ifdef SPIKE_PACK_STATS_EN
  logic [31:0] total_q, total_d;
  logic [32:0] total_sum;

  // Saturating count of spikes in accepted vectors; clr takes priority
  always_comb begin
    total_sum = {1'b0, total_q} + 33'(popcount(spike_in));
    total_d   = total_q;
    if (clr) begin
      total_d = '0;
    end else if (accept) begin
      total_d = total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign spike_total = total_q;
`else
  assign spike_total = 32'd0;
`endif

endmodule

// File: tb/tb_spike_pack_buffer.sv
// Bench for spike_pack_buffer: queue-based word model, directed scenarios and random traffic.
module tb_spike_pack_buffer;

  localparam int T     = 16;
  localparam int NPACK = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] spike_in;
  logic        spike_valid, spike_last, flush, out_ready, clr;
  logic        in_ready, out_last, out_valid, overflow;
  logic [63:0] out_data;
  logic [2:0]  out_count;
  logic [31:0] spike_total;

  spike_pack_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .spike_in    (spike_in),
    .spike_valid (spike_valid),
    .spike_last  (spike_last),
    .flush       (flush),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow),
    .clr         (clr),
    .spike_total (spike_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          cnt;
    bit          last;
  } word_t;

  logic [15:0] m_slots[$];
  word_t       m_fifo[$];
  bit          m_pend;
  bit          m_ovf;
  longint      m_total;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t mk_word(input bit last);
    word_t w;
    w.data = 64'd0;
    foreach (m_slots[k]) w.data = w.data | (64'(m_slots[k]) << (k * T));
    w.cnt  = m_slots.size();
    w.last = last;
    return w;
  endfunction

  function automatic logic [63:0] exp_total();
`ifdef SPIKE_PACK_STATS_EN
    return 64'(m_total);
`else
    return 64'd0;
`endif
  endfunction

  task automatic compare();
    chk("out_valid", 64'(out_valid), 64'(m_fifo.size() > 0));
    chk("in_ready", 64'(in_ready), 64'((m_fifo.size() < DEPTH) && !m_pend));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("spike_total", 64'(spike_total), exp_total());
    if (m_fifo.size() > 0 && out_valid) begin
      chk("out_data", out_data, m_fifo[0].data);
      chk("out_count", 64'(out_count), 64'(m_fifo[0].cnt));
      chk("out_last", 64'(out_last), 64'(m_fifo[0].last));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, then check.
  task automatic step(input bit v, input logic [15:0] vec, input bit last, input bit fl,
                      input bit ordy, input bit cl);
    bit    ready, pop, have;
    word_t w;
    spike_valid = v; spike_in = vec; spike_last = last; flush = fl;
    out_ready = ordy; clr = cl;
    ready = (m_fifo.size() < DEPTH) && !m_pend;
    pop   = (m_fifo.size() > 0) && ordy;
    have  = 1'b0;
    if (v && ready) begin
      m_slots.push_back(vec);
      if (m_slots.size() == NPACK || last || fl) begin
        w = mk_word(last || fl);
        have = 1'b1;
        m_slots.delete();
      end
    end else if (m_pend || (fl && m_slots.size() > 0)) begin
      if (m_fifo.size() < DEPTH) begin
        w = mk_word(1'b1);
        have = 1'b1;
        m_slots.delete();
        m_pend = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end
    if (v && !ready) m_ovf = 1'b1;
    else if (cl) m_ovf = 1'b0;
    if (cl) m_total = 0;
    else if (v && ready) begin
      m_total = m_total + longint'($countones(vec));
      if (m_total > 64'h0000_0000_FFFF_FFFF) m_total = 64'h0000_0000_FFFF_FFFF;
    end
    if (pop) m_fifo.delete(0);
    if (have) m_fifo.push_back(w);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    spike_valid = 1'b0; spike_in = 16'd0; spike_last = 1'b0;
    flush = 1'b0; out_ready = 1'b0; clr = 1'b0;
    rst = 1'b1;
    m_slots.delete(); m_fifo.delete();
    m_pend = 1'b0; m_ovf = 1'b0; m_total = 0;
    @(negedge clk);
    compare();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    spike_valid = 1'b0; spike_in = 16'd0; spike_last = 1'b0;
    flush = 1'b0; out_ready = 1'b0; clr = 1'b0;
    do_reset();
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Full word of four vectors
    step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_no_word_yet", 64'(out_valid), 64'd0);
    step(1'b1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_data", out_data, 64'h8000_0004_0002_0001);
    chk("t1_count", 64'(out_count), 64'd4);
    chk("t1_last", 64'(out_last), 64'd0);
    idle(1);

    // Early close by spike_last, next vector restarts at slot 0
    step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2_data", out_data, 64'h0000_0000_5555_AAAA);
    chk("t2_count", 64'(out_count), 64'd2);
    chk("t2_last", 64'(out_last), 64'd1);
    step(1'b1, 16'h0007, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2_slot0", out_data, 64'h0000_0000_0000_0007);
    idle(1);

    // Fill FIFO under backpressure, drop, drain, clear
    for (int i = 0; i < 16; i++) step(1'b1, 16'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_head", out_data, 64'h0004_0003_0002_0001);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_overflow", 64'(overflow), 64'd1);
    idle(4);
    chk("t3_drained", 64'(out_valid), 64'd0);
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3_ovf_clr", 64'(overflow), 64'd0);

    // Reset mid-word discards the partial word
    step(1'b1, 16'h0009, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    chk("t4_no_word", 64'(out_valid), 64'd0);
    step(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0033, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0044, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_data", out_data, 64'h0044_0033_0022_0011);
    idle(2);

    // flush behaviour
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_empty_flush", 64'(out_valid), 64'd0);
    step(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0303, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_flush_data", out_data, 64'h0000_0303_0202_0101);
    chk("t5_flush_count", 64'(out_count), 64'd3);
    chk("t5_flush_last", 64'(out_last), 64'd1);
    step(1'b1, 16'h00F0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Spike statistics
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SPIKE_PACK_STATS_EN
    chk("t6_total", 64'(spike_total), 64'd33);
`else
    chk("t6_total", 64'(spike_total), 64'd0);
`endif
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_total_clr", 64'(spike_total), 64'd0);

    // Random traffic with varying backpressure phases
    for (int i = 0; i < 4000; i++) begin
      bit ordy;
      ordy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, ordy, $urandom_range(0, 63) == 0);
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
